demux8_bridge: RTL and testbench
================================

DEMUX8_BRIDGE -- requirements
Module: demux8_bridge

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data payload width in bits.
REQ-002 The block SHALL have parameter EN_MASK, default 8'hFF, meaning bit i = 1 if target i is enabled.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream beat is valid.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-007 The block SHALL have port in_sel, input, 3, the target index 0..7 for the beat.
REQ-008 The block SHALL have port in_data, input, WIDTH, the beat payload.
REQ-009 The block SHALL have port out_valid, output, 8, a one-hot per-target valid.
REQ-010 The block SHALL have port out_ready, input, 8, the per-target ready.
REQ-011 The block SHALL have port out_data, output, WIDTH, the payload shared by all targets.
REQ-012 The block SHALL have port drop_cnt, output, 16, the dropped-beat count (present only under DEMUX8_DROP_CNT_EN).

Function
REQ-013 Accept SHALL occur when in_valid && in_ready; the beat is captured on that rising edge.
REQ-014 Storage SHALL be an in-order 2-entry FIFO (head + skid) of {sel[2:0], data}; count is 0..2.
REQ-015 in_ready SHALL be registered and equal to (count < 2), independent of in_valid and out_ready in the same cycle.
REQ-016 While count > 0, out_valid SHALL equal (8'b1 << head.sel) and out_data SHALL equal head.data; while count == 0, out_valid SHALL be 8'h00 and out_data SHALL be 0.
REQ-017 Pop SHALL occur when count > 0 && out_ready[head.sel]; ready bits of non-selected targets SHALL be ignored.
REQ-018 Latency: a beat accepted into an empty FIFO SHALL be presented on the next cycle; beat order SHALL be preserved, with head-of-line blocking across targets.
REQ-019 A simultaneous push and pop with count == 1 SHALL leave count at 1, with the new beat becoming head.
REQ-020 A simultaneous push and pop with count == 0 SHALL NOT occur; the pushed beat becomes head and no pop happens.
REQ-021 A beat accepted with EN_MASK[in_sel] == 0 SHALL be consumed but not enqueued; count is unchanged and in_ready is unaffected.
REQ-022 out_valid SHALL never have more than one bit set, and a bit SHALL never be set for a disabled target.
REQ-023 Once asserted, out_valid and out_data SHALL hold stable until the pop.

Reset
REQ-024 Asserting reset SHALL asynchronously clear count to 0, out_valid to 8'h00, out_data to 0, in_ready to 1, and drop_cnt to 0.
REQ-025 Asserting reset mid-operation SHALL discard all buffered beats; no beat SHALL be presented after deassertion unless newly accepted.
REQ-026 The first accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-027 With macro DEMUX8_DROP_CNT_EN defined, port drop_cnt SHALL exist and increment by 1 per dropped beat (REQ-021), saturating at 16'hFFFF.
REQ-028 Without DEMUX8_DROP_CNT_EN, port drop_cnt and its counter SHALL be absent; drops still occur silently.

Verification
REQ-029 Scenario: reset, then accept sel=5, data=32'hDEADBEEF -> next cycle out_valid=8'h20, out_data=32'hDEADBEEF; out_ready[5]=1 pops it, and the following cycle out_valid=8'h00.
REQ-030 Scenario: hold out_ready=0 and offer 3 beats -> two are accepted, in_ready=0 on the cycle after the second accept, and the third beat is held upstream.
REQ-031 Scenario: head sel=2, out_ready=8'hFB -> no pop, head stable; then out_ready=8'h04 -> pop.
REQ-032 Scenario: count=1 with simultaneous push (sel=7, data=1) and pop -> count stays 1 and out_valid=8'h80 next cycle.
REQ-033 Scenario: EN_MASK=8'hFE, accept sel=0 -> no out_valid, count unchanged; with the macro defined drop_cnt=1, and after 65536 such drops drop_cnt=16'hFFFF.
REQ-034 Scenario: with count=2, assert reset between edges -> outputs clear immediately, before the next edge, and in_ready=1.

Source files
------------

// File: rtl/demux8_bridge.sv
// demux8_bridge: 1-to-8 valid/ready demux behind a 2-entry in-order FIFO.
// Optional macro DEMUX8_DROP_CNT_EN adds a saturating dropped-beat counter port.
module demux8_bridge #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [7:0]  EN_MASK = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DEMUX8_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    logic [1:0]       count;
    logic [2:0]       head_sel;
    logic [WIDTH-1:0] head_data;
    logic [2:0]       skid_sel;
    logic [WIDTH-1:0] skid_data;

    logic [1:0]       count_n;
    logic [2:0]       head_sel_n;
    logic [WIDTH-1:0] head_data_n;
    logic [2:0]       skid_sel_n;
    logic [WIDTH-1:0] skid_data_n;

    logic accept;
    logic push;
    logic pop;

    // Handshake decode: accepted beats to disabled targets are consumed, never queued
    always_comb begin
        accept = in_valid && in_ready;
        push   = accept && EN_MASK[in_sel];
        pop    = (count != 2'd0) && out_ready[head_sel];
    end

    // Next-state FIFO update; skid only fills while the head is still waiting
    always_comb begin
        count_n     = count;
        head_sel_n  = head_sel;
        head_data_n = head_data;
        skid_sel_n  = skid_sel;
        skid_data_n = skid_data;
        unique case (count)
            2'd0: begin
                if (push) begin
                    head_sel_n  = in_sel;
                    head_data_n = in_data;
                    count_n     = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_sel_n  = in_sel;
                    head_data_n = in_data;
                end else if (push) begin
                    skid_sel_n  = in_sel;
                    skid_data_n = in_data;
                    count_n     = 2'd2;
                end else if (pop) begin
                    count_n     = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_sel_n  = skid_sel;
                    head_data_n = skid_data;
                    count_n     = 2'd1;
                end
            end
            default: begin
                count_n = 2'd0;
            end
        endcase
    end

    // State and registered outputs; reset empties the FIFO immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= 2'd0;
            head_sel  <= 3'd0;
            head_data <= '0;
            skid_sel  <= 3'd0;
            skid_data <= '0;
            in_ready  <= 1'b1;
            out_valid <= 8'h00;
            out_data  <= '0;
        end else begin
            count     <= count_n;
            head_sel  <= head_sel_n;
            head_data <= head_data_n;
            skid_sel  <= skid_sel_n;
            skid_data <= skid_data_n;
            in_ready  <= (count_n < 2'd2);
            if (count_n != 2'd0) begin
                out_valid <= 8'b1 << head_sel_n;
                out_data  <= head_data_n;
            end else begin
                out_valid <= 8'h00;
                out_data  <= '0;
            end
        end
    end

`ifdef DEMUX8_DROP_CNT_EN
    // Saturating count of beats consumed for disabled targets
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= 16'h0000;
        end else if (accept && !EN_MASK[in_sel] && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_demux8_bridge.sv
// tb_demux8_bridge: directed bench for demux8_bridge (EN_MASK=8'hFE).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_demux8_bridge;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [31:0] in_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [31:0] out_data;
`ifdef DEMUX8_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    demux8_bridge #(
        .WIDTH(32),
        .EN_MASK(8'hFE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sel(in_sel),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
`ifdef DEMUX8_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_sel = 3'd0;
        in_data = 32'h0;
        out_ready = 8'h00;
        step();
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %h expected 00", out_valid);
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
`ifdef DEMUX8_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: got %h expected 0", drop_cnt);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_basic();
        in_valid = 1'b1;
        in_sel = 3'd5;
        in_data = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 8'h20) begin
            n_fail++;
            $display("FAIL basic_valid: got %h expected 20", out_valid);
        end
        n_checks++;
        if (out_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_data: got %h expected deadbeef", out_data);
        end
        out_ready = 8'h20;
        step();
        out_ready = 8'h00;
        n_checks++;
        if (out_valid !== 8'h00 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_pop: got %h/%h expected 00/0", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 8'h00;
        in_valid = 1'b1;
        in_sel = 3'd1;
        in_data = 32'hA1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 8'h02) begin
            n_fail++;
            $display("FAIL bp_first: got rdy=%b v=%h expected 1/02", in_ready, out_valid);
        end
        in_sel = 3'd3;
        in_data = 32'hA2;
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got %b expected 0", in_ready);
        end
        in_sel = 3'd4;
        in_data = 32'hA3;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 8'h02 || out_data !== 32'hA1) begin
            n_fail++;
            $display("FAIL bp_hold: got rdy=%b v=%h d=%h expected 0/02/a1",
                     in_ready, out_valid, out_data);
        end
        out_ready = 8'h02;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 8'h08 || out_data !== 32'hA2) begin
            n_fail++;
            $display("FAIL bp_pop1: got rdy=%b v=%h d=%h expected 1/08/a2",
                     in_ready, out_valid, out_data);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 8'h08 || out_data !== 32'hA2) begin
            n_fail++;
            $display("FAIL bp_third_in: got rdy=%b v=%h d=%h expected 0/08/a2",
                     in_ready, out_valid, out_data);
        end
        out_ready = 8'hFF;
        step();
        n_checks++;
        if (out_valid !== 8'h10 || out_data !== 32'hA3) begin
            n_fail++;
            $display("FAIL bp_pop2: got v=%h d=%h expected 10/a3", out_valid, out_data);
        end
        step();
        out_ready = 8'h00;
        n_checks++;
        if (out_valid !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%h rdy=%b expected 00/1", out_valid, in_ready);
        end
    endtask

    task automatic test_hol();
        in_valid = 1'b1;
        in_sel = 3'd2;
        in_data = 32'hC2;
        step();
        in_valid = 1'b0;
        out_ready = 8'hFB;
        step();
        n_checks++;
        if (out_valid !== 8'h04 || out_data !== 32'hC2) begin
            n_fail++;
            $display("FAIL hol_stall: got v=%h d=%h expected 04/c2", out_valid, out_data);
        end
        out_ready = 8'h04;
        step();
        out_ready = 8'h00;
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_fail++;
            $display("FAIL hol_pop: got %h expected 00", out_valid);
        end
    endtask

    task automatic test_push_pop();
        in_valid = 1'b1;
        in_sel = 3'd6;
        in_data = 32'h66;
        step();
        in_sel = 3'd7;
        in_data = 32'h1;
        out_ready = 8'h40;
        step();
        in_valid = 1'b0;
        out_ready = 8'h00;
        n_checks++;
        if (out_valid !== 8'h80 || out_data !== 32'h1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_swap: got v=%h d=%h rdy=%b expected 80/1/1",
                     out_valid, out_data, in_ready);
        end
        out_ready = 8'h80;
        step();
        out_ready = 8'h00;
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_fail++;
            $display("FAIL pp_drain: got %h expected 00 (count was not 1)", out_valid);
        end
    endtask

    task automatic test_drop();
        in_valid = 1'b1;
        in_sel = 3'd0;
        in_data = 32'hBAD0;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_empty: got v=%h rdy=%b expected 00/1", out_valid, in_ready);
        end
`ifdef DEMUX8_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_cnt1: got %h expected 0001", drop_cnt);
        end
`endif
        in_valid = 1'b1;
        in_sel = 3'd3;
        in_data = 32'h33;
        step();
        in_sel = 3'd0;
        in_data = 32'hBAD1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 8'h08 || out_data !== 32'h33) begin
            n_fail++;
            $display("FAIL drop_busy: got rdy=%b v=%h d=%h expected 1/08/33",
                     in_ready, out_valid, out_data);
        end
        out_ready = 8'h08;
        step();
        out_ready = 8'h00;
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_drain: got %h expected 00", out_valid);
        end
`ifdef DEMUX8_DROP_CNT_EN
        in_valid = 1'b1;
        in_sel = 3'd0;
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (drop_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL drop_sat: got %h expected ffff", drop_cnt);
        end
`endif
    endtask

    task automatic test_async_reset();
        out_ready = 8'h00;
        in_valid = 1'b1;
        in_sel = 3'd1;
        in_data = 32'h11;
        step();
        in_sel = 3'd5;
        in_data = 32'h55;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 8'h02) begin
            n_fail++;
            $display("FAIL ar_full: got rdy=%b v=%h expected 0/02", in_ready, out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 8'h00 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_clear: got v=%h d=%h rdy=%b expected 00/0/1",
                     out_valid, out_data, in_ready);
        end
`ifdef DEMUX8_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL ar_drop_cnt: got %h expected 0", drop_cnt);
        end
`endif
        #1;
        reset = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_fail++;
            $display("FAIL ar_stale: got %h expected 00", out_valid);
        end
        reset = 1'b1;
        #1;
        reset = 1'b0;
        in_valid = 1'b1;
        in_sel = 3'd7;
        in_data = 32'h77;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 8'h80 || out_data !== 32'h77) begin
            n_fail++;
            $display("FAIL ar_first_accept: got v=%h d=%h expected 80/77", out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_hol();
        test_push_pop();
        test_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
